// File: rtl/defuzzification.sv
// ============================================================================
// Module   : defuzzification
// Summary  : Weighted-average centroid defuzzifier driven by a multi-cycle
//            restoring divider. Define DEFUZZ_ROUND_EN for round-half-away.
// Revision : 1.0
// ============================================================================
`default_nettype none

module defuzzification #(
    parameter int ACC_W     = 24,
    parameter int MAX_TERMS = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               term_valid,
    output logic               term_ready,
    input  logic [6:0]         term_idx,
    input  logic [7:0]         term_w,
    input  logic               term_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [15:0] crisp,
    output logic               err,
    output logic               ovf
);

    localparam int DEN_W = 8 + $clog2(MAX_TERMS);
    localparam int CNT_W = $clog2(MAX_TERMS + 1);
    localparam int DCW   = $clog2(ACC_W + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_TERMS);
    localparam logic [DCW-1:0]   DIV_LAST = DCW'(ACC_W);
    localparam logic [ACC_W-1:0] POS_MAX  = ACC_W'(32767);
    localparam logic [ACC_W-1:0] NEG_MAX  = ACC_W'(32768);

    typedef enum logic [1:0] {
        S_ACC  = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic                    armed;
    logic signed [ACC_W-1:0] num;
    logic [DEN_W-1:0]        den;
    logic [CNT_W-1:0]        cnt;
    logic                    err_acc;
    logic                    ovf_acc;
    logic [DCW-1:0]          div_cnt;
    logic [ACC_W-1:0]        dq;
    logic [DEN_W-1:0]        rem;

    logic                    accept;
    logic                    div_done;
    logic signed [7:0]       center;
    logic signed [16:0]      prod;
    logic [ACC_W-1:0]        abs_num;
    logic [ACC_W-1:0]        dividend;
    logic [DEN_W:0]          rem_sh;
    logic [DEN_W-1:0]        rem_sub;
    logic                    q_bit;
    logic [ACC_W-1:0]        quo_nxt;
    logic [DEN_W-1:0]        rem_nxt;
    logic signed [15:0]      sat_val;

    assign term_ready = (state == S_ACC) && armed;
    assign out_valid  = (state == S_DONE);
    assign accept     = term_valid && term_ready;
    assign div_done   = (state == S_DIV) && (div_cnt == DIV_LAST);

    always_comb begin
        center = 8'sd0;
        case (term_idx)
            7'd0:  center = -8'sd85;  7'd1:  center = -8'sd75;  7'd2:  center = -8'sd65;
            7'd3:  center = -8'sd59;  7'd4:  center = -8'sd56;  7'd5:  center = -8'sd53;
            7'd6:  center = -8'sd50;  7'd7:  center = -8'sd47;  7'd8:  center = -8'sd44;
            7'd9:  center = -8'sd41;  7'd10: center = -8'sd38;  7'd11: center = -8'sd35;
            7'd12: center = -8'sd31;  7'd13: center = -8'sd29;  7'd14: center = -8'sd27;
            7'd15: center = -8'sd25;  7'd16: center = -8'sd21;  7'd17: center = -8'sd19;
            7'd18: center = -8'sd18;  7'd19: center = -8'sd17;  7'd20: center = -8'sd16;
            7'd21: center = -8'sd15;  7'd22: center = -8'sd14;  7'd23: center = -8'sd12;
            7'd24: center = 8'sd0;    7'd25: center = 8'sd12;   7'd26: center = 8'sd14;
            7'd27: center = 8'sd16;   7'd28: center = 8'sd19;   7'd29: center = 8'sd21;
            7'd30: center = 8'sd22;   7'd31: center = 8'sd23;   7'd32: center = 8'sd24;
            7'd33: center = 8'sd25;   7'd34: center = 8'sd26;   7'd35: center = 8'sd27;
            7'd36: center = 8'sd29;   7'd37: center = 8'sd32;   7'd38: center = 8'sd35;
            7'd39: center = 8'sd38;   7'd40: center = 8'sd41;   7'd41: center = 8'sd44;
            7'd42: center = 8'sd47;   7'd43: center = 8'sd50;   7'd44: center = 8'sd53;
            7'd45: center = 8'sd56;   7'd46: center = 8'sd59;   7'd47: center = 8'sd65;
            7'd48: center = 8'sd75;
            default: center = 8'sd0;
        endcase
    end

    assign prod = $signed({1'b0, term_w}) * center;

    // One restoring step: shift the next dividend bit into the partial remainder.
    always_comb begin
        abs_num = num[ACC_W-1] ? $unsigned(-num) : $unsigned(num);
`ifdef DEFUZZ_ROUND_EN
        dividend = abs_num + ACC_W'(den >> 1);
`else
        dividend = abs_num;
`endif
        rem_sh  = {rem, dq[ACC_W-1]};
        q_bit   = (rem_sh >= {1'b0, den});
        rem_sub = rem_sh[DEN_W-1:0] - den;
        rem_nxt = q_bit ? rem_sub : rem_sh[DEN_W-1:0];
        quo_nxt = {dq[ACC_W-2:0], q_bit};
    end

    always_comb begin
        sat_val = 16'sd0;
        if (den != '0) begin
            if (!num[ACC_W-1]) begin
                sat_val = (quo_nxt > POS_MAX) ? 16'sh7fff : $signed(quo_nxt[15:0]);
            end else begin
                sat_val = (quo_nxt > NEG_MAX) ? 16'sh8000 : $signed(-quo_nxt[15:0]);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_ACC:   if (accept && term_last) state_nxt = S_DIV;
            S_DIV:   if (div_done)            state_nxt = S_DONE;
            S_DONE:  if (out_ready)           state_nxt = S_ACC;
            default:                          state_nxt = S_ACC;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_ACC;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed   <= 1'b0;
            num     <= '0;
            den     <= '0;
            cnt     <= '0;
            err_acc <= 1'b0;
            ovf_acc <= 1'b0;
            div_cnt <= '0;
            dq      <= '0;
            rem     <= '0;
            crisp   <= 16'sd0;
            err     <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            armed <= 1'b1;
            case (state)
                S_ACC: begin
                    div_cnt <= '0;
                    if (accept) begin
                        if (cnt == CNT_MAX) begin
                            ovf_acc <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                            if (term_idx > 7'd48) begin
                                err_acc <= 1'b1;
                            end else begin
                                num <= num + {{(ACC_W-17){prod[16]}}, prod};
                                den <= den + {{(DEN_W-8){1'b0}}, term_w};
                            end
                        end
                    end
                end
                S_DIV: begin
                    // Step 0 loads the dividend; steps 1..ACC_W each retire one quotient bit.
                    if (div_cnt == '0) begin
                        dq      <= dividend;
                        rem     <= '0;
                        div_cnt <= div_cnt + 1'b1;
                    end else begin
                        dq      <= quo_nxt;
                        rem     <= rem_nxt;
                        div_cnt <= div_cnt + 1'b1;
                        if (div_cnt == DIV_LAST) begin
                            crisp <= sat_val;
                            err   <= err_acc || (den == '0);
                            ovf   <= ovf_acc;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        num     <= '0;
                        den     <= '0;
                        cnt     <= '0;
                        err_acc <= 1'b0;
                        ovf_acc <= 1'b0;
                        crisp   <= 16'sd0;
                        err     <= 1'b0;
                        ovf     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_defuzzification.sv
// ============================================================================
// Module   : tb_defuzzification
// Summary  : Randomized scoreboard bench for the defuzzification block.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_defuzzification;

    localparam int ACC_W     = 24;
    localparam int MAX_TERMS = 64;
    localparam int PERIOD    = 10;
    localparam int HALF      = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              term_valid = 1'b0;
    logic              term_ready;
    logic [6:0]        term_idx = '0;
    logic [7:0]        term_w = '0;
    logic              term_last = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic signed [15:0] crisp;
    logic              err;
    logic              ovf;

    defuzzification #(.ACC_W(ACC_W), .MAX_TERMS(MAX_TERMS)) dut (
        .clk        (clk),
        .rst        (rst),
        .term_valid (term_valid),
        .term_ready (term_ready),
        .term_idx   (term_idx),
        .term_w     (term_w),
        .term_last  (term_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .crisp      (crisp),
        .err        (err),
        .ovf        (ovf)
    );

    always #HALF clk = ~clk;

    typedef struct {
        int     crisp;
        bit     err;
        bit     ovf;
        longint t_last;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    bit   hold_low = 1'b0;
    bit   rand_bp  = 1'b0;
    int   f_idx[$];
    int   f_w[$];

    int CENTER[49] = '{-85, -75, -65, -59, -56, -53, -50, -47, -44, -41, -38, -35, -31,
                       -29, -27, -25, -21, -19, -18, -17, -16, -15, -14, -12, 0,
                       12, 14, 16, 19, 21, 22, 23, 24, 25, 26, 27, 29,
                       32, 35, 38, 41, 44, 47, 50, 53, 56, 59, 65, 75};

    task automatic chk(input string name, input int act, input int exp_v);
        n_vec++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp_v, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s at t=%0t", name, $time);
    endtask

    // Centroid of the frame currently held in f_idx/f_w, computed with plain integer arithmetic.
    function automatic exp_t model();
        exp_t   e;
        longint num = 0;
        longint den = 0;
        longint a;
        longint q;
        int     n = 0;
        e.err = 1'b0;
        e.ovf = 1'b0;
        e.t_last = 0;
        for (int i = 0; i < f_idx.size(); i++) begin
            if (n == MAX_TERMS) begin
                e.ovf = 1'b1;
            end else begin
                n++;
                if (f_idx[i] > 48) e.err = 1'b1;
                else begin
                    num += longint'(f_w[i] * CENTER[f_idx[i]]);
                    den += longint'(f_w[i]);
                end
            end
        end
        if (den == 0) begin
            e.crisp = 0;
            e.err   = 1'b1;
        end else begin
            a = (num < 0) ? -num : num;
`ifdef DEFUZZ_ROUND_EN
            a = a + den / 2;
`endif
            q = a / den;
            if (num < 0) q = -q;
            if (q > 32767)  q = 32767;
            if (q < -32768) q = -32768;
            e.crisp = int'(q);
        end
        return e;
    endfunction

    task automatic send_term(input int idx, input int w, input bit last, input exp_t e_in);
        int   guard = 0;
        exp_t e = e_in;
        @(negedge clk);
        while (!term_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (!term_ready) begin
            fail_now("term_ready_timeout");
            return;
        end
        term_valid = 1'b1;
        term_idx   = 7'(idx);
        term_w     = 8'(w);
        term_last  = last;
        @(posedge clk);
        if (last) begin
            e.t_last = $time;
            sb.push_back(e);
        end
        #1;
        term_valid = 1'b0;
        term_last  = 1'b0;
    endtask

    task automatic send_frame();
        exp_t e = model();
        for (int i = 0; i < f_idx.size(); i++)
            send_term(f_idx[i], f_w[i], (i == f_idx.size() - 1), e);
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() > 0 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() > 0) fail_now("drain_timeout");
    endtask

    task automatic wait_valid();
        int guard = 0;
        @(negedge clk);
        while (!out_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!out_valid) fail_now("out_valid_timeout");
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            out_ready = hold_low ? 1'b0 : (rand_bp ? 1'($urandom_range(0, 1)) : 1'b1);
        end
    end

    // Monitor: latency on rising out_valid, hold-stability under backpressure, scoreboard pop on handshake.
    initial begin
        bit   pv = 1'b0;
        bit   hs = 1'b0;
        int   pc = 0;
        bit   pe = 1'b0;
        bit   po = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 1'b0;
                hs = 1'b0;
            end else begin
                if (hs) chk("term_ready_after_handshake", int'(term_ready), 1);
                hs = 1'b0;
                if (out_valid) begin
                    chk("term_ready_low_in_done", int'(term_ready), 0);
                    if (!pv) begin
                        if (sb.size() > 0)
                            chk("latency_edges", int'(($time - HALF - sb[0].t_last) / PERIOD), ACC_W + 1);
                    end else begin
                        chk("crisp_stable", int'(crisp), pc);
                        chk("err_stable", int'(err), int'(pe));
                        chk("ovf_stable", int'(ovf), int'(po));
                    end
                    pc = int'(crisp);
                    pe = err;
                    po = ovf;
                    if (out_ready) begin
                        if (sb.size() == 0) fail_now("unexpected_output");
                        else begin
                            e = sb.pop_front();
                            chk("crisp", int'(crisp), e.crisp);
                            chk("err", int'(err), int'(e.err));
                            chk("ovf", int'(ovf), int'(e.ovf));
                        end
                        hs = 1'b1;
                    end
                end
                pv = out_valid;
            end
        end
    end

    initial begin
        #12;
        chk("reset_term_ready", int'(term_ready), 0);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_crisp", int'(crisp), 0);
        chk("reset_err", int'(err), 0);
        chk("reset_ovf", int'(ovf), 0);
        #11 rst = 1'b0;
        #1 chk("ready_before_first_edge", int'(term_ready), 0);
        @(negedge clk);
        chk("ready_after_first_edge", int'(term_ready), 1);

        f_idx = '{24};      f_w = '{100};   send_frame();
        f_idx = '{2, 46};   f_w = '{1, 1};  send_frame();
        f_idx = '{47, 48};  f_w = '{3, 1};  send_frame();
        f_idx = '{1, 2};    f_w = '{1, 3};  send_frame();
        f_idx = '{10, 60};  f_w = '{0, 5};  send_frame();
        f_idx = '{30};      f_w = '{2};     send_frame();
        drain();

        hold_low = 1'b1;
        f_idx = '{40}; f_w = '{10}; send_frame();
        wait_valid();
        repeat (10) @(negedge clk);
        hold_low = 1'b0;
        drain();

        f_idx.delete();
        f_w.delete();
        for (int i = 0; i < MAX_TERMS + 2; i++) begin
            f_idx.push_back(36);
            f_w.push_back(1);
        end
        send_frame();
        drain();

        rand_bp = 1'b1;
        repeat (40) begin
            int n = int'($urandom_range(1, 6));
            f_idx.delete();
            f_w.delete();
            for (int i = 0; i < n; i++) begin
                f_idx.push_back(($urandom_range(0, 9) == 0) ? int'($urandom_range(49, 127))
                                                           : int'($urandom_range(0, 48)));
                f_w.push_back(int'($urandom_range(0, 255)));
            end
            send_frame();
        end
        drain();
        rand_bp = 1'b0;

        f_idx = '{5}; f_w = '{7}; send_frame();
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("rst_div_out_valid", int'(out_valid), 0);
        chk("rst_div_term_ready", int'(term_ready), 0);
        chk("rst_div_crisp", int'(crisp), 0);
        sb.delete();
        #10 rst = 1'b0;

        hold_low = 1'b1;
        f_idx = '{20}; f_w = '{3}; send_frame();
        wait_valid();
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("rst_done_out_valid", int'(out_valid), 0);
        chk("rst_done_term_ready", int'(term_ready), 0);
        chk("rst_done_crisp", int'(crisp), 0);
        sb.delete();
        #10 rst = 1'b0;
        hold_low = 1'b0;

        f_idx = '{0}; f_w = '{1}; send_frame();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #300000;
        fail_now("global_watchdog");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
